// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline constants and types for the fetch stage.
package riscv_pipe_pkg;

  localparam logic [31:0] NOP_INSN_DEF = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC       = 32'd4;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_skid_buf.sv
// Single-entry {insn, pc} holding buffer used when a response lands on a stalled slot.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        clear,
  input  logic [31:0] insn_in,
  input  logic [31:0] pc_in,
  output logic        valid,
  output logic [31:0] insn,
  output logic [31:0] pc
);

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end
  end

  // NOTE: the payload is qualified by valid, so it needs no reset and stays a plain register.
  always_ff @(posedge clk) begin
    if (load) begin
      insn <= insn_in;
      pc   <= pc_in;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage driving the IF/ID register; single outstanding imem request.
// Optional macro FETCH_PERF_CNT_EN adds stall_cycles and flush_count counters.
module fetch_unit
  import riscv_pipe_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSN = NOP_INSN_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hazard_detection,
  input  logic        NextPCSrc,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_out,
  output logic [31:0] sum_out,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0] stall_cycles,
  output logic [31:0] flush_count,
`endif
  output logic        fetch_valid
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic         kill;
  logic         slot_free;
  logic         skid_load;
  logic         skid_clear;
  logic         skid_valid;
  logic [31:0]  skid_insn;
  logic [31:0]  skid_pc;

  assign slot_free = !fetch_valid || !hazard_detection;
  assign imem_req  = (state == REQ) && !rst;
  assign imem_addr = pc;

  // Buffer fills only for a live response that cannot enter a stalled slot.
  assign skid_load  = !rst && !NextPCSrc && (state == WAIT) && imem_rvalid
                      && !kill && !slot_free;
  assign skid_clear = NextPCSrc || ((state == HOLD) && slot_free);

  fetch_skid_buf u_skid (
    .clk     (clk),
    .rst     (rst),
    .load    (skid_load),
    .clear   (skid_clear),
    .insn_in (imem_rdata),
    .pc_in   (pc),
    .valid   (skid_valid),
    .insn    (skid_insn),
    .pc      (skid_pc)
  );

  // NOTE: every state register uses non-blocking assignment so all updates see pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= REQ;
      pc              <= RESET_PC;
      kill            <= 1'b0;
      instruction_out <= NOP_INSN;
      pc_out          <= '0;
      sum_out         <= '0;
      fetch_valid     <= 1'b0;
    end else if (NextPCSrc) begin
      pc              <= branch_target;
      fetch_valid     <= 1'b0;
      instruction_out <= NOP_INSN;
      case (state)
        REQ: begin
          if (imem_ready) begin
            kill  <= 1'b1;
            state <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            kill  <= 1'b0;
            state <= REQ;
          end else begin
            kill  <= 1'b1;
          end
        end
        default: state <= REQ;
      endcase
    end else begin
      // Default: a free slot with nothing new drains to a bubble.
      if (slot_free) begin
        fetch_valid     <= 1'b0;
        instruction_out <= NOP_INSN;
      end
      case (state)
        REQ: begin
          if (imem_ready) state <= WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (kill) begin
              kill  <= 1'b0;
              state <= REQ;
            end else if (slot_free) begin
              instruction_out <= imem_rdata;
              pc_out          <= pc;
              sum_out         <= pc + PC_INC;
              fetch_valid     <= 1'b1;
              pc              <= pc + PC_INC;
              state           <= REQ;
            end else begin
              pc    <= pc + PC_INC;
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (slot_free && skid_valid) begin
            instruction_out <= skid_insn;
            pc_out          <= skid_pc;
            sum_out         <= skid_pc + PC_INC;
            fetch_valid     <= 1'b1;
            state           <= REQ;
          end else if (slot_free) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      if (fetch_valid && hazard_detection) stall_cycles <= stall_cycles + 32'd1;
      if (NextPCSrc) flush_count <= flush_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit with a hand-driven imem port.
module tb_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        hazard_detection;
  logic        NextPCSrc;
  logic [31:0] branch_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [31:0] pc_out;
  logic [31:0] sum_out;
  logic        fetch_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] flush_count;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk              (clk),
    .rst              (rst),
    .hazard_detection (hazard_detection),
    .NextPCSrc        (NextPCSrc),
    .branch_target    (branch_target),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rvalid      (imem_rvalid),
    .imem_rdata       (imem_rdata),
    .instruction_out  (instruction_out),
    .pc_out           (pc_out),
    .sum_out          (sum_out),
`ifdef FETCH_PERF_CNT_EN
    .stall_cycles     (stall_cycles),
    .flush_count      (flush_count),
`endif
    .fetch_valid      (fetch_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one edge; outputs are sampled 1ns after it and inputs change there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    imem_ready  = 1'b0;
    imem_rvalid = 1'b0;
    NextPCSrc   = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    hazard_detection = 1'b0;
    branch_target = '0;
    imem_rdata = '0;
    idle();
    step();
    step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, fetch_valid}, 32'd0);
    check("rst_insn", instruction_out, NOP);
    check("rst_pc_out", pc_out, 32'd0);
    check("rst_sum", sum_out, 32'd0);
    rst = 1'b0;
    #1;
    check("req_after_rst", {31'd0, imem_req}, 32'd1);
    check("addr_after_rst", imem_addr, 32'd0);

    // Basic fetch: ready now, rvalid next cycle.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    check("wait_req_low", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'h0050_0093;
    step();
    imem_rvalid = 1'b0;
    check("f1_insn", instruction_out, 32'h0050_0093);
    check("f1_pc", pc_out, 32'd0);
    check("f1_sum", sum_out, 32'd4);
    check("f1_valid", {31'd0, fetch_valid}, 32'd1);
    check("f1_next_addr", imem_addr, 32'd4);
    check("f1_next_req", {31'd0, imem_req}, 32'd1);

    // Stall while the pc=4 response arrives; it parks in the skid buffer.
    hazard_detection = 1'b1;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h00a0_0113;
    step();
    imem_rvalid = 1'b0;
    check("stall_pc_held", pc_out, 32'd0);
    check("stall_insn_held", instruction_out, 32'h0050_0093);
    check("hold_req_low", {31'd0, imem_req}, 32'd0);
    check("hold_pc_adv", imem_addr, 32'd8);
    step();
    check("stall3_pc_held", pc_out, 32'd0);
    check("stall3_req_low", {31'd0, imem_req}, 32'd0);
    hazard_detection = 1'b0;
    step();
    check("release_insn", instruction_out, 32'h00a0_0113);
    check("release_pc", pc_out, 32'd4);
    check("release_sum", sum_out, 32'd8);
    check("release_valid", {31'd0, fetch_valid}, 32'd1);
    check("release_req", {31'd0, imem_req}, 32'd1);
    step();
    check("drain_valid", {31'd0, fetch_valid}, 32'd0);
    check("drain_insn", instruction_out, NOP);
    check("drain_pc_held", pc_out, 32'd4);
    check("drain_sum_held", sum_out, 32'd8);

    // Redirect while in WAIT; the late response is dropped.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    NextPCSrc = 1'b1; branch_target = 32'h100;
    step();
    NextPCSrc = 1'b0;
    check("redir_w_valid", {31'd0, fetch_valid}, 32'd0);
    check("redir_w_insn", instruction_out, NOP);
    check("redir_w_req", {31'd0, imem_req}, 32'd0);
    imem_rvalid = 1'b1; imem_rdata = 32'hdead_beef;
    step();
    imem_rvalid = 1'b0;
    check("kill_w_valid", {31'd0, fetch_valid}, 32'd0);
    check("kill_w_insn", instruction_out, NOP);
    check("kill_w_addr", imem_addr, 32'h100);
    check("kill_w_req", {31'd0, imem_req}, 32'd1);

    // Redirect in the same cycle the request is accepted.
    imem_ready = 1'b1; NextPCSrc = 1'b1; branch_target = 32'h200;
    step();
    idle();
    check("redir_r_req", {31'd0, imem_req}, 32'd0);
    check("redir_r_addr", imem_addr, 32'h200);
    imem_rvalid = 1'b1; imem_rdata = 32'hbad0_bad0;
    step();
    imem_rvalid = 1'b0;
    check("kill_r_valid", {31'd0, fetch_valid}, 32'd0);
    check("kill_r_req", {31'd0, imem_req}, 32'd1);
    check("kill_r_addr", imem_addr, 32'h200);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    step();
    imem_rvalid = 1'b0;
    check("tgt_insn", instruction_out, 32'h1111_1111);
    check("tgt_pc", pc_out, 32'h200);
    check("tgt_sum", sum_out, 32'h204);

    // PC wrap at the top of the address space.
    NextPCSrc = 1'b1; branch_target = 32'hFFFF_FFFC;
    step();
    NextPCSrc = 1'b0;
    check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    check("wrap_redir_valid", {31'd0, fetch_valid}, 32'd0);
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    step();
    imem_rvalid = 1'b0;
    check("wrap_pc", pc_out, 32'hFFFF_FFFC);
    check("wrap_sum", sum_out, 32'd0);
    check("wrap_next_addr", imem_addr, 32'd0);

    // Reset during WAIT; the response after reset is ignored.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    step();
    imem_rvalid = 1'b0;
    check("rstw_valid", {31'd0, fetch_valid}, 32'd0);
    check("rstw_insn", instruction_out, NOP);
    check("rstw_addr", imem_addr, 32'd0);
    check("rstw_req", {31'd0, imem_req}, 32'd1);

    // Stall and redirect together in HOLD: redirect wins and the buffer is discarded.
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h4444_4444;
    step();
    imem_rvalid = 1'b0;
    check("sr_first_pc", pc_out, 32'd0);
    hazard_detection = 1'b1;
    imem_ready = 1'b1;
    step();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1; imem_rdata = 32'h5555_5555;
    step();
    imem_rvalid = 1'b0;
    NextPCSrc = 1'b1; branch_target = 32'h40;
    step();
    NextPCSrc = 1'b0;
    check("sr_valid", {31'd0, fetch_valid}, 32'd0);
    check("sr_insn", instruction_out, NOP);
    check("sr_addr", imem_addr, 32'h40);
    check("sr_req", {31'd0, imem_req}, 32'd1);
`ifdef FETCH_PERF_CNT_EN
    check("perf_stall", stall_cycles, 32'd3);
    check("perf_flush", flush_count, 32'd1);
`endif
    hazard_detection = 1'b0;
    step();
    check("sr_no_leak_valid", {31'd0, fetch_valid}, 32'd0);
    check("sr_no_leak_insn", instruction_out, NOP);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage and write side of the IF/ID pipeline register.
- Owns the PC and issues single-outstanding requests to instruction memory.
- Presents {instruction, pc, pc+4} to IF/ID with a valid bit, honouring the decode-side stall (hazard_detection) and the branch redirect (NextPCSrc).
- Sits between the imem port and the IF/ID register.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset.
NOP_INSN, 32'h0000_0013, instruction presented when the output slot is empty or flushed (addi x0,x0,0).

Ports:
clk  in  1  single clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
hazard_detection  in  1  stall from decode: the output slot is held and not consumed.
NextPCSrc  in  1  redirect: flush and refetch from branch_target.
branch_target  in  32  redirect PC, sampled when NextPCSrc=1.
imem_req  out  1  fetch request valid.
imem_addr  out  32  fetch address; equals the pc register.
imem_ready  in  1  memory accepts the request this cycle when imem_req=1.
imem_rvalid  in  1  response valid.
imem_rdata  in  32  response instruction.
instruction_out  out  32  fetched instruction to IF/ID.
pc_out  out  32  PC of instruction_out.
sum_out  out  32  pc_out+4, modulo 2^32.
fetch_valid  out  1  output slot holds a real instruction.

Behaviour:
- Reset, synchronous, when rst=1 at the clock edge:
  - pc=RESET_PC, state=REQ, kill=0, skid buffer empty.
  - instruction_out=NOP_INSN, pc_out=0, sum_out=0, fetch_valid=0.
  - imem_req is 0 while rst is high.
  - An in-flight response is abandoned. Any imem_rvalid seen outside WAIT is ignored.
- Slot consumption: the slot is "free" when fetch_valid=0 or hazard_detection=0.
- FSM states: REQ, WAIT, HOLD.
  - REQ: imem_req=1, imem_addr=pc. On imem_ready=1, go to WAIT; pc is unchanged until the response arrives.
  - WAIT: imem_req=0. On imem_rvalid=1 with kill=0:
    - Slot free: instruction_out<=imem_rdata, pc_out<=pc, sum_out<=pc+4, fetch_valid<=1, pc<=pc+4, go to REQ.
    - Slot not free: capture {rdata, pc} in the skid buffer, pc<=pc+4, go to HOLD.
  - WAIT, imem_rvalid=1 with kill=1: drop the data, kill<=0, go to REQ.
  - HOLD: imem_req=0. When the slot becomes free, move the buffer into the outputs with fetch_valid<=1, then go to REQ.
- Slot free with no new data: fetch_valid<=0 and instruction_out<=NOP_INSN; pc_out and sum_out are held.
- Latency: REQ with immediate ready plus next-cycle rvalid gives 2 cycles per instruction. Outputs update the edge after rvalid.
- Redirect (NextPCSrc=1) has priority over stall and response:
  - pc<=branch_target, fetch_valid<=0, instruction_out<=NOP_INSN, skid buffer cleared.
  - In WAIT without rvalid the same cycle: kill<=1 and stay in WAIT.
  - In WAIT with rvalid the same cycle: drop the response and go to REQ.
  - In REQ with imem_ready the same cycle: kill<=1 and go to WAIT. The accepted request is killed.
  - In HOLD: go to REQ.
- Stall and redirect in the same cycle: the redirect wins.
- PC arithmetic wraps at 32 bits: pc=32'hFFFF_FFFC gives sum_out=0 and next pc=0.
- branch_target alignment is not checked.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- Defined:
  - Adds outputs stall_cycles[31:0] and flush_count[31:0], both reset to 0 and wrapping.
  - stall_cycles increments in every cycle with fetch_valid=1 and hazard_detection=1.
  - flush_count increments in every cycle with NextPCSrc=1.
- Undefined: both ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package riscv_pipe_pkg: NOP_INSN constant, RESET_PC default, fetch state enum {REQ, WAIT, HOLD}, and the PC_INC=4 constant.
- One natural sub-module: fetch_skid_buf, a single-entry {insn, pc} buffer with load, clear and valid.

Test Plan:
- Reset, then imem_ready=1 and rvalid the next cycle with data 32'h00500093 -> pc_out=0, sum_out=4, fetch_valid=1; next imem_addr=4.
- Hold hazard_detection=1 for 3 cycles while the response for pc=4 arrives -> outputs stay at pc 0 and state is HOLD; after release, pc_out=4 and instruction_out=buffer data.
- NextPCSrc=1 with branch_target=32'h100 while in WAIT -> fetch_valid=0, instruction_out=NOP_INSN; next rvalid dropped; imem_addr=32'h100.
- Redirect in the same cycle as imem_ready -> the accepted request's response is discarded, then the request goes to the target.
- pc=32'hFFFF_FFFC fetch -> sum_out=0 and next imem_addr=0.
- Assert rst in WAIT with rvalid the following cycle -> response ignored; imem_addr=RESET_PC and fetch_valid=0.
